// File: rtl/rtc_write_sequencer_pkg.sv
// Shared definitions for the RTC write sequencer and the read-side register bank:
// state encoding, register count and the index-to-address map.
package rtc_write_sequencer_pkg;

    localparam int NUM_REGS = 11;
    localparam int IDX_W    = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_GAP,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_NEXT,
        S_FINISH
    } seq_state_t;

    // Index i of the write burst lands on RTC register REG_ADDR[i].
    localparam logic [7:0] REG_ADDR [NUM_REGS] = '{
        8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h41, 8'h42, 8'h43, 8'h21
    };

    // Lowest set bit of a non-empty mask; returns 0 for an empty mask.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REGS-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rtc_write_sequencer_if.sv
// Request side and multiplexed RTC bus of the write sequencer.
// start is a one-cycle request, honoured only while busy=0; done pulses once per accepted start.
interface rtc_write_sequencer_if;

    logic                                         start;
    logic [rtc_write_sequencer_pkg::NUM_REGS-1:0] wr_mask;
    logic [7:0] data_0, data_1, data_2, data_3, data_4, data_5;
    logic [7:0] data_6, data_7, data_8, data_9, data_10;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       wr_n;
    logic       aod;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        input  start, wr_mask,
        input  data_0, data_1, data_2, data_3, data_4, data_5,
        input  data_6, data_7, data_8, data_9, data_10,
        output busy, done, cs_n, wr_n, aod, ad_out, ad_oe
    );

    modport slave (
        output start, wr_mask,
        output data_0, data_1, data_2, data_3, data_4, data_5,
        output data_6, data_7, data_8, data_9, data_10,
        input  busy, done, cs_n, wr_n, aod, ad_out, ad_oe
    );

endinterface

// File: rtl/rtc_write_sequencer_bus_phase_timer.sv
// Down-counter reloaded at the entry of each timed bus phase; phase_done marks
// the last cycle of that phase.
module rtc_write_sequencer_bus_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             phase_done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_done = (cnt == '0);

endmodule

// File: rtl/rtc_write_sequencer.sv
// Write-side master of the RTC address/data bus: snapshots up to 11 bytes on start
// and writes each masked one as an address phase followed by a data phase.
module rtc_write_sequencer
    import rtc_write_sequencer_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rtc_write_sequencer_if.master bus,
    output seq_state_t          dbg_state
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    seq_state_t          state, state_next;
    logic [NUM_REGS-1:0] pending, pending_next;
    logic [IDX_W-1:0]    cur_idx, idx_next;
    logic [7:0]          snap_data [NUM_REGS];

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             phase_done;

    logic       cs_n_q, wr_n_q, aod_q, ad_oe_q, busy_q, done_q;
    logic [7:0] ad_out_q;
    logic       cs_n_d, wr_n_d, aod_d, ad_oe_d, busy_d, done_d;
    logic [7:0] ad_out_d;

    rtc_write_sequencer_bus_phase_timer #(.CNT_W(CNT_W)) u_bus_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_val   (timer_val),
        .phase_done (phase_done)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending;
        idx_next     = cur_idx;
        case (state)
            S_IDLE:     if (bus.start) begin
                            state_next   = S_NEXT;
                            pending_next = bus.wr_mask;
                        end
            S_A_SETUP:  if (phase_done) state_next = S_A_STROBE;
            S_A_STROBE: if (phase_done) state_next = S_A_HOLD;
            S_A_HOLD:   if (phase_done) state_next = S_GAP;
            S_GAP:      state_next = S_D_SETUP;
            S_D_SETUP:  if (phase_done) state_next = S_D_STROBE;
            S_D_STROBE: if (phase_done) state_next = S_D_HOLD;
            S_D_HOLD:   if (phase_done) state_next = S_NEXT;
            S_NEXT:     if (pending != '0) begin
                            state_next   = S_A_SETUP;
                            idx_next     = lowest_set(pending);
                            pending_next = pending & ~(NUM_REGS'(1) << idx_next);
                        end else begin
                            state_next = S_FINISH;
                        end
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // The timer is reloaded on the edge that enters a timed phase.
    always_comb begin
        timer_val = '0;
        case (state_next)
            S_A_SETUP, S_D_SETUP:   timer_val = SETUP_LD;
            S_A_STROBE, S_D_STROBE: timer_val = PULSE_LD;
            S_A_HOLD, S_D_HOLD:     timer_val = HOLD_LD;
            default:                timer_val = '0;
        endcase
        timer_load = (state_next != state) &&
                     (state_next inside {S_A_SETUP, S_A_STROBE, S_A_HOLD,
                                         S_D_SETUP, S_D_STROBE, S_D_HOLD});
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        aod_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_next)
            S_IDLE:   ad_out_d = 8'h00;
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                wr_n_d   = (state_next != S_A_STROBE);
                ad_out_d = REG_ADDR[idx_next];
                busy_d   = 1'b1;
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                aod_d    = 1'b0;
                wr_n_d   = (state_next != S_D_STROBE);
                ad_out_d = snap_data[idx_next];
                busy_d   = 1'b1;
            end
            S_GAP, S_NEXT: busy_d = 1'b1;
            S_FINISH:      done_d = 1'b1;
            default:       busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pending  <= '0;
            cur_idx  <= '0;
            for (int i = 0; i < NUM_REGS; i++) snap_data[i] <= 8'h00;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            aod_q    <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            cur_idx  <= idx_next;
            if (state == S_IDLE && bus.start) begin
                snap_data[0]  <= bus.data_0;
                snap_data[1]  <= bus.data_1;
                snap_data[2]  <= bus.data_2;
                snap_data[3]  <= bus.data_3;
                snap_data[4]  <= bus.data_4;
                snap_data[5]  <= bus.data_5;
                snap_data[6]  <= bus.data_6;
                snap_data[7]  <= bus.data_7;
                snap_data[8]  <= bus.data_8;
                snap_data[9]  <= bus.data_9;
                snap_data[10] <= bus.data_10;
            end
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            aod_q    <= aod_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cs_n   = cs_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.aod    = aod_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.ad_out = ad_out_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: a default-timing instance (a) and a 1/1/1 instance (b),
// a bus monitor acting as the read-side register bank, and a pair-level reference model.
`timescale 1ns/1ps
module tb_rtc_write_sequencer;
    import rtc_write_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_write_sequencer_if bus_a ();
    rtc_write_sequencer_if bus_b ();
    seq_state_t dbg_a, dbg_b;

    rtc_write_sequencer dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_a));
    rtc_write_sequencer #(.SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .CNT_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_b));

    // ---------------- stimulus variables ----------------
    logic        sa = 1'b0, sb = 1'b0;
    logic [10:0] ma = '0, mb = '0;
    logic [7:0]  da [11];
    logic [7:0]  db [11];

    assign bus_a.start = sa;  assign bus_a.wr_mask = ma;
    assign bus_b.start = sb;  assign bus_b.wr_mask = mb;
    assign bus_a.data_0 = da[0]; assign bus_a.data_1 = da[1]; assign bus_a.data_2 = da[2];
    assign bus_a.data_3 = da[3]; assign bus_a.data_4 = da[4]; assign bus_a.data_5 = da[5];
    assign bus_a.data_6 = da[6]; assign bus_a.data_7 = da[7]; assign bus_a.data_8 = da[8];
    assign bus_a.data_9 = da[9]; assign bus_a.data_10 = da[10];
    assign bus_b.data_0 = db[0]; assign bus_b.data_1 = db[1]; assign bus_b.data_2 = db[2];
    assign bus_b.data_3 = db[3]; assign bus_b.data_4 = db[4]; assign bus_b.data_5 = db[5];
    assign bus_b.data_6 = db[6]; assign bus_b.data_7 = db[7]; assign bus_b.data_8 = db[8];
    assign bus_b.data_9 = db[9]; assign bus_b.data_10 = db[10];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_a [$];
    logic [15:0] got_b [$];
    logic [7:0]  bank [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] ref_addr(input int i);
        if (i < 7) return 8'(8'h22 + i);
        case (i)
            7:       return 8'h41;
            8:       return 8'h42;
            9:       return 8'h43;
            default: return 8'h21;
        endcase
    endfunction

    task automatic build_exp(input logic [10:0] mask, input logic [7:0] d [11]);
        exp_q.delete();
        for (int i = 0; i < 11; i++) if (mask[i]) exp_q.push_back({ref_addr(i), d[i]});
    endtask

    // ---------------- bus monitor ----------------
    int   first_fall [2], done_cyc [2], done_cnt [2], busy_rise [2], busy_cyc [2];
    int   bad_width [2], aod_bad [2], low_len [2];
    int   pulse_len [2] = '{4, 1};
    logic prev_cs [2], prev_wr [2], prev_busy [2], aod_at_fall [2];
    logic [7:0] last_addr [2];

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            first_fall[k] = -1; done_cyc[k] = -1; done_cnt[k] = 0; busy_rise[k] = 0;
            busy_cyc[k] = 0; bad_width[k] = 0; aod_bad[k] = 0;
        end
        got_a.delete();
        got_b.delete();
        for (int i = 0; i < 256; i++) bank[i] = 8'h00;
    endtask

    initial begin
        logic cs, wr, ao, bs, dn;
        logic [7:0] ad;
        for (int k = 0; k < 2; k++) begin
            prev_cs[k] = 1'b1; prev_wr[k] = 1'b1; prev_busy[k] = 1'b0;
            low_len[k] = 0; aod_at_fall[k] = 1'b1; last_addr[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cs = (k == 0) ? bus_a.cs_n   : bus_b.cs_n;
                wr = (k == 0) ? bus_a.wr_n   : bus_b.wr_n;
                ao = (k == 0) ? bus_a.aod    : bus_b.aod;
                bs = (k == 0) ? bus_a.busy   : bus_b.busy;
                dn = (k == 0) ? bus_a.done   : bus_b.done;
                ad = (k == 0) ? bus_a.ad_out : bus_b.ad_out;
                if (!rst_n) begin
                    prev_cs[k] = 1'b1; prev_wr[k] = 1'b1; prev_busy[k] = 1'b0; low_len[k] = 0;
                end else begin
                    if (prev_cs[k] && !cs && first_fall[k] < 0) first_fall[k] = cyc;
                    if (!wr) begin
                        if (prev_wr[k]) aod_at_fall[k] = ao;
                        else if (ao != aod_at_fall[k]) aod_bad[k]++;
                        low_len[k]++;
                    end
                    if (!prev_wr[k] && wr) begin
                        if (low_len[k] != pulse_len[k]) bad_width[k]++;
                        low_len[k] = 0;
                        if (ao) last_addr[k] = ad;
                        else if (k == 0) begin
                            got_a.push_back({last_addr[k], ad});
                            bank[last_addr[k]] = ad;
                        end else got_b.push_back({last_addr[k], ad});
                    end
                    if (dn) begin done_cnt[k]++; done_cyc[k] = cyc; end
                    if (bs) busy_cyc[k]++;
                    if (bs && !prev_busy[k]) busy_rise[k]++;
                    prev_cs[k] = cs; prev_wr[k] = wr; prev_busy[k] = bs;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_burst(input int k, output int st);
        step();
        if (k == 0) sa = 1'b1; else sb = 1'b1;
        st = cyc + 1;
        step();
        sa = 1'b0;
        sb = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int n = 0;
        while (done_cnt[k] == 0 && n < limit) begin step(); n++; end
        check("done_seen", 32'(done_cnt[k] != 0), 32'd1);
    endtask

    task automatic cmp_got(input int k, input string tag);
        int sz;
        logic [15:0] g;
        sz = (k == 0) ? got_a.size() : got_b.size();
        check({tag, "_count"}, 32'(sz), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sz; i++) begin
            g = (k == 0) ? got_a[i] : got_b[i];
            check({tag, "_pair"}, 32'(g), 32'(exp_q[i]));
        end
    endtask

    task automatic rand_data(input int k);
        for (int i = 0; i < 11; i++) begin
            if (k == 0) da[i] = 8'($urandom_range(0, 255));
            else        db[i] = 8'($urandom_range(0, 255));
        end
    endtask

    function automatic logic [31:0] bus_word(input int k);
        if (k == 0) return {17'd0, bus_a.cs_n, bus_a.wr_n, bus_a.aod, bus_a.ad_oe,
                            bus_a.busy, bus_a.done, 1'b0, bus_a.ad_out};
        return {17'd0, bus_b.cs_n, bus_b.wr_n, bus_b.aod, bus_b.ad_oe,
                bus_b.busy, bus_b.done, 1'b0, bus_b.ad_out};
    endfunction

    localparam logic [31:0] RESET_WORD = {17'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // ---------------- test sequence ----------------
    initial begin
        int st, n, target;
        logic [7:0] snap [11];
        for (int i = 0; i < 11; i++) begin da[i] = 8'h00; db[i] = 8'h00; end
        clear_mon();
        repeat (3) step();
        check("reset_outputs_a", bus_word(0), RESET_WORD);
        check("reset_outputs_b", bus_word(1), RESET_WORD);
        check("reset_state_a", 32'(dbg_a), 32'(S_IDLE));
        rst_n = 1'b1;
        repeat (2) step();

        // full mask, data 10+i
        clear_mon();
        ma = 11'h7FF;
        for (int i = 0; i < 11; i++) da[i] = 8'(8'h10 + i);
        build_exp(ma, da);
        run_burst(0, st);
        wait_done(0, 400);
        cmp_got(0, "full");
        check("full_first_fall", 32'(first_fall[0] - st), 32'd1);
        check("full_done_delay", 32'(done_cyc[0] - first_fall[0]), 32'd198);
        for (int i = 0; i < 11; i++) check("bank", 32'(bank[ref_addr(i)]), 32'(8'h10 + i));
        check("full_strobe_width", 32'(bad_width[0]), 32'd0);
        check("full_aod_stable", 32'(aod_bad[0]), 32'd0);
        check("full_busy_len", 32'(busy_cyc[0]), 32'(done_cyc[0] - st));
        step();
        check("idle_after_done", bus_word(0), RESET_WORD);

        // first and last index only
        clear_mon();
        ma = 11'b100_0000_0001;
        rand_data(0);
        build_exp(ma, da);
        run_burst(0, st);
        wait_done(0, 200);
        cmp_got(0, "ends");
        check("ends_bus_cycles", 32'(done_cyc[0] - first_fall[0]), 32'd36);
        repeat (5) step();
        check("ends_done_once", 32'(done_cnt[0]), 32'd1);

        // empty mask
        clear_mon();
        ma = 11'h000;
        run_burst(0, st);
        wait_done(0, 20);
        repeat (5) step();
        check("empty_no_cs", 32'(first_fall[0]), 32'hFFFF_FFFF);
        check("empty_done_delay", 32'(done_cyc[0] - st), 32'd1);
        check("empty_busy_len", 32'(busy_cyc[0]), 32'd1);

        // data change plus a second start while busy
        clear_mon();
        ma = 11'h7FF;
        rand_data(0);
        for (int i = 0; i < 11; i++) snap[i] = da[i];
        build_exp(ma, snap);
        run_burst(0, st);
        repeat (4) step();
        da[3] = ~da[3];
        sa = 1'b1;
        step();
        sa = 1'b0;
        wait_done(0, 400);
        repeat (30) step();
        cmp_got(0, "snap");
        check("snap_done_once", 32'(done_cnt[0]), 32'd1);
        check("snap_busy_rises", 32'(busy_rise[0]), 32'd1);
        check("snap_busy_len", 32'(busy_cyc[0]), 32'(done_cyc[0] - st));

        // reset during the data strobe of index 4
        clear_mon();
        ma = 11'h7FF;
        rand_data(0);
        build_exp(ma, da);
        run_burst(0, st);
        target = st + 1 + 4 * 18 + 12;
        n = 0;
        while (cyc != target && n < 300) begin step(); n++; end
        check("pre_reset_strobe", {30'd0, bus_a.wr_n, bus_a.aod}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", bus_word(0), RESET_WORD);
        check("reset_partial_pairs", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) check("reset_pair", 32'(got_a[i]), 32'(exp_q[i]));
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_state", 32'(dbg_a), 32'(S_IDLE));
        clear_mon();
        ma = 11'($urandom_range(1, 2047));
        rand_data(0);
        build_exp(ma, da);
        run_burst(0, st);
        wait_done(0, 400);
        cmp_got(0, "after_reset");

        // randomized bursts on the default instance
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            ma = 11'($urandom_range(1, 2047));
            rand_data(0);
            build_exp(ma, da);
            run_burst(0, st);
            wait_done(0, 400);
            cmp_got(0, "rand");
            check("rand_bus_cycles", 32'(done_cyc[0] - first_fall[0]), 32'(18 * $countones(ma)));
            check("rand_strobe_width", 32'(bad_width[0]), 32'd0);
        end

        // 1/1/1 timing instance
        for (int r = 0; r < 2; r++) begin
            clear_mon();
            mb = (r == 0) ? 11'h7FF : 11'($urandom_range(1, 2047));
            rand_data(1);
            build_exp(mb, db);
            run_burst(1, st);
            wait_done(1, 200);
            cmp_got(1, "fast");
            check("fast_strobe_width", 32'(bad_width[1]), 32'd0);
            check("fast_aod_stable", 32'(aod_bad[1]), 32'd0);
            check("fast_bus_cycles", 32'(done_cyc[1] - first_fall[1]), 32'(8 * $countones(mb)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
- Write-side master for the multiplexed RTC address/data bus. The existing register bank is the read-side capture end of this bus.
- On a start request, it snapshots up to 11 byte values and writes each one to its RTC register. Each write is an address phase (aod=1) followed by a data phase (aod=0), strobed by cs_n/wr_n.
- The controller uses it to program time, date and timer values into the RTC.

Parameters:
- SETUP_CYCLES, 2, cycles ad_out/aod are stable with cs_n=0 before the wr_n falling edge (min 1)
- PULSE_CYCLES, 4, wr_n low width in cycles (min 1)
- HOLD_CYCLES, 2, cycles ad_out/aod are held with cs_n=0 after the wr_n rising edge (min 1)
- CNT_W, 8, timing counter width; must hold max(SETUP,PULSE,HOLD)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a write burst
- wr_mask  in  11  bit i=1 means index i is written
- data_0 .. data_10  in  8 each  values to write, indices 0..10
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when a burst completes
- cs_n  out  1  bus chip select, active low
- wr_n  out  1  bus write strobe, active low
- aod  out  1  1 = address phase, 0 = data phase
- ad_out  out  8  multiplexed address/data byte
- ad_oe  out  1  bus driver enable, 1 while cs_n=0

Behaviour:
- Reset values (asynchronous, and in the IDLE state): cs_n=1, wr_n=1, aod=1, ad_out=8'h00, ad_oe=0, busy=0, done=0.
- Fixed index-to-address map:
  - 0..6 -> 8'h22..8'h28
  - 7 -> 8'h41, 8 -> 8'h42, 9 -> 8'h43, 10 -> 8'h21
- Start acceptance:
  - start is accepted only in IDLE.
  - On acceptance, data_0..data_10 and wr_mask are registered into a snapshot; later input changes do not affect the burst.
  - start while busy is ignored, not queued.
- Registers are written in ascending index order, skipping indices whose mask bit is 0.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, NEXT, FINISH.
- Address phase:
  - A_SETUP: SETUP_CYCLES cycles, cs_n=0, ad_oe=1, aod=1, ad_out=mapped address, wr_n=1.
  - A_STROBE: PULSE_CYCLES cycles, same outputs but wr_n=0.
  - A_HOLD: HOLD_CYCLES cycles, wr_n=1, address still driven.
- GAP: exactly 1 cycle, cs_n=1, ad_oe=0, wr_n=1, aod=1, ad_out holds its last value.
- Data phase:
  - D_SETUP, D_STROBE, D_HOLD behave as the address phase, but with aod=0 and ad_out=snapshot data.
- NEXT: 1 cycle, bus idle (cs_n=1, ad_oe=0, aod=1).
  - Selects the next masked index and returns to A_SETUP.
  - If no masked index remains, goes to FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Cycle timing:
  - Cycles per written register = 2*(SETUP+PULSE+HOLD) + 2. This is 18 with the defaults.
  - With the defaults, cs_n first goes low on the 2nd cycle after the start edge.
- Empty mask: start is accepted, there is no bus activity, and done pulses on the 2nd cycle after start.
- aod changes only while cs_n=1 or one cycle before cs_n falls. It never changes while wr_n=0.
- Reset mid-burst: all outputs return immediately to their reset values and the snapshot is discarded. A partially written register is not retried.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package contains:
  - the state enum;
  - the 11-entry register address constant table (shared with the read-side register bank);
  - NUM_REGS=11.
- One natural sub-module, bus_phase_timer: loads SETUP/PULSE/HOLD counts and emits a phase_done pulse. Instantiate it once, reloaded per phase.

Test Plan:
- Reset, then start with wr_mask=11'h7FF and data_i=8'h10+i.
  - Expect 11 address/data pairs on the bus: (22,10), (23,11) … (28,16), (41,17), (42,18), (43,19), (21,1A).
  - Expect done exactly 198 cycles after the first cs_n fall plus the trailing NEXT/FINISH.
  - A scoreboard modelling the read-side register bank captures all 11 values.
- wr_mask=11'b100_0000_0001 -> only (22,d0) and (21,d10) are written; 36 bus cycles; done pulses once.
- wr_mask=0 -> cs_n stays 1 throughout; done on the 2nd cycle after start; busy pulse 1 cycle.
- Change data_3 and pulse start again 5 cycles into a burst -> the bus carries the snapshot value of data_3, there is no second burst, and busy stays high continuously.
- Assert rst_n=0 during the D_STROBE of index 4 -> wr_n and cs_n go to 1 asynchronously; after release, the block is IDLE and a new start works.
- Timing check with SETUP=1, PULSE=1, HOLD=1:
  - wr_n low exactly 1 cycle per phase;
  - aod stable for the whole time wr_n=0;
  - each register takes 8 cycles.
